m_wbioarb: RTL and testbench

M_WBIOARB -- requirements
Module: m_wbioarb

---
 rtl/m_wbioarb_pkg.sv | 24 ++
 rtl/m_wbioarb_rr.sv | 41 ++++
 rtl/m_wbioarb.sv | 164 ++++++++++++++++
 tb/tb_m_wbioarb.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_wbioarb_pkg.sv
// m_wbioarb shared types: FSM states, grant codes, latched request.
// Watchdog width applies when WBIOARB_TIMEOUT_EN is defined.
package m_wbioarb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUSY    = 2'b01,
    ST_RECOVER = 2'b10
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam int unsigned WDOG_W = 8;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wb_req_t;

endpackage

// File: rtl/m_wbioarb_rr.sv
// m_wbioarb_rr: two-input pick, round-robin or fixed M0 priority.
// Pointer remembers whether M1 owned the bus last.
module m_wbioarb_rr
  import m_wbioarb_pkg::*;
#(
  parameter int unsigned FIXEDPRIO = 0
) (
  input  logic       clklf,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] pick
);

  logic m1_last_q;

  // pick winner from current requests and pointer
  always_comb begin
    pick = GNT_NONE;
    unique case (req)
      2'b11: begin
        if (FIXEDPRIO != 0 || m1_last_q)
          pick = GNT_M0;
        else
          pick = GNT_M1;
      end
      2'b01:   pick = GNT_M0;
      2'b10:   pick = GNT_M1;
      default: pick = GNT_NONE;
    endcase
  end

  // remember last owner when a grant is taken
  always_ff @(posedge clklf or negedge rst_n) begin
    if (!rst_n)
      m1_last_q <= 1'b1;
    else if (take)
      m1_last_q <= pick[1];
  end

endmodule

// File: rtl/m_wbioarb.sv
// m_wbioarb: two-master Wishbone arbiter onto one IO slave.
// Define WBIOARB_TIMEOUT_EN for the slave-ACK watchdog.
module m_wbioarb
  import m_wbioarb_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned FIXEDPRIO = 0
) (
  input  logic        CLK_I,
  input  logic        RST_NI,
  input  logic        M0_STB_I,
  input  logic        M0_WE_I,
  input  logic [31:0] M0_ADR_I,
  input  logic [31:0] M0_DAT_I,
  input  logic [3:0]  M0_SEL_I,
  output logic        M0_ACK_O,
  output logic        M0_ERR_O,
  output logic [31:0] M0_DAT_O,
  input  logic        M1_STB_I,
  input  logic        M1_WE_I,
  input  logic [31:0] M1_ADR_I,
  input  logic [31:0] M1_DAT_I,
  input  logic [3:0]  M1_SEL_I,
  output logic        M1_ACK_O,
  output logic        M1_ERR_O,
  output logic [31:0] M1_DAT_O,
  output logic        S_STB_O,
  output logic        S_WE_O,
  output logic [31:0] S_ADR_O,
  output logic [31:0] S_DAT_O,
  output logic [3:0]  S_SEL_O,
  input  logic        S_ACK_I,
  input  logic [31:0] S_DAT_I,
  output logic [1:0]  gnt
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_tmo
    $error("m_wbioarb: TIMEOUT must be 2..255");
  end

  state_t     state_q;
  state_t     state_d;
  logic [1:0] gnt_q;
  logic [1:0] req;
  logic [1:0] pick;
  logic       take;
  logic       stb_q;
  logic       busy;
  logic       owner_stb;
  logic       abort;
  logic       fin_ack;
  logic       tmo_hit;
  wb_req_t    m0_req;
  wb_req_t    m1_req;
  wb_req_t    req_q;

  assign req       = {M1_STB_I, M0_STB_I};
  assign take      = (state_q == ST_IDLE) && (|req);
  assign busy      = (state_q == ST_BUSY);
  assign owner_stb = |(gnt_q & req);
  assign abort     = busy && !owner_stb;
  assign fin_ack   = busy && owner_stb && S_ACK_I;

  assign m0_req = '{we: M0_WE_I, adr: M0_ADR_I,
                    dat: M0_DAT_I, sel: M0_SEL_I};
  assign m1_req = '{we: M1_WE_I, adr: M1_ADR_I,
                    dat: M1_DAT_I, sel: M1_SEL_I};

  m_wbioarb_rr #(
    .FIXEDPRIO(FIXEDPRIO)
  ) u_rr (
    .clklf(CLK_I),
    .rst_n(RST_NI),
    .req  (req),
    .take (take),
    .pick (pick)
  );

`ifdef WBIOARB_TIMEOUT_EN
  localparam logic [WDOG_W-1:0] WDOG_LIM =
    WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] wdog_q;

  // count cycles spent in BUSY, cleared elsewhere
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI)
      wdog_q <= '0;
    else if (busy)
      wdog_q <= wdog_q + 1'b1;
    else
      wdog_q <= '0;
  end

  assign tmo_hit = busy && owner_stb && !S_ACK_I &&
                   (wdog_q == WDOG_LIM);
`else
  assign tmo_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // next-state: grant, finish on ack/abort/timeout, one idle gap
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req)
          state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (abort || fin_ack || tmo_hit)
          state_d = ST_RECOVER;
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // latch owner and its request; slave strobe is a clean flop
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      gnt_q <= GNT_NONE;
      req_q <= '0;
      stb_q <= 1'b0;
    end else begin
      stb_q <= (state_d == ST_BUSY);
      if (take) begin
        gnt_q <= pick;
        req_q <= pick[1] ? m1_req : m0_req;
      end else if (state_q == ST_RECOVER) begin
        gnt_q <= GNT_NONE;
      end
    end
  end

  // route ack/err/data to the owner only
  always_comb begin
    M0_ACK_O = gnt_q[0] && (fin_ack || tmo_hit);
    M1_ACK_O = gnt_q[1] && (fin_ack || tmo_hit);
    M0_ERR_O = gnt_q[0] && tmo_hit;
    M1_ERR_O = gnt_q[1] && tmo_hit;
    M0_DAT_O = '0;
    M1_DAT_O = '0;
    if (gnt_q[0] && fin_ack)
      M0_DAT_O = S_DAT_I;
    if (gnt_q[1] && fin_ack)
      M1_DAT_O = S_DAT_I;
  end

  assign S_STB_O = stb_q;
  assign S_WE_O  = req_q.we;
  assign S_ADR_O = req_q.adr;
  assign S_DAT_O = req_q.dat;
  assign S_SEL_O = req_q.sel;
  assign gnt     = gnt_q;

endmodule

// File: tb/tb_m_wbioarb.sv
// tb_m_wbioarb: directed vectors plus corner sequences.
// Instance a is round-robin, instance b is fixed priority.
module tb_m_wbioarb;

  localparam logic [31:0] M0A = 32'h6000_0004;
  localparam logic [31:0] M0D = 32'h0000_0007;
  localparam logic [3:0]  M0S = 4'hF;
  localparam logic [31:0] M1A = 32'h6000_0100;
  localparam logic [31:0] M1D = 32'h0000_0055;
  localparam logic [3:0]  M1S = 4'h3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_stb, m0_we, m1_stb, m1_we, s_ack;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
  logic [3:0]  m0_sel, m1_sel;

  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err;
  logic [31:0] a_m0_dat, a_m1_dat, a_s_adr, a_s_dat;
  logic        a_s_stb, a_s_we;
  logic [3:0]  a_s_sel;
  logic [1:0]  a_gnt;

  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
  logic [31:0] b_m0_dat, b_m1_dat, b_s_adr, b_s_dat;
  logic        b_s_stb, b_s_we;
  logic [3:0]  b_s_sel;
  logic [1:0]  b_gnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  m_wbioarb #(.TIMEOUT(15), .FIXEDPRIO(0)) u_a (
    .CLK_I(clk), .RST_NI(rst_n),
    .M0_STB_I(m0_stb), .M0_WE_I(m0_we),
    .M0_ADR_I(m0_adr), .M0_DAT_I(m0_dat),
    .M0_SEL_I(m0_sel), .M0_ACK_O(a_m0_ack),
    .M0_ERR_O(a_m0_err), .M0_DAT_O(a_m0_dat),
    .M1_STB_I(m1_stb), .M1_WE_I(m1_we),
    .M1_ADR_I(m1_adr), .M1_DAT_I(m1_dat),
    .M1_SEL_I(m1_sel), .M1_ACK_O(a_m1_ack),
    .M1_ERR_O(a_m1_err), .M1_DAT_O(a_m1_dat),
    .S_STB_O(a_s_stb), .S_WE_O(a_s_we),
    .S_ADR_O(a_s_adr), .S_DAT_O(a_s_dat),
    .S_SEL_O(a_s_sel), .S_ACK_I(s_ack),
    .S_DAT_I(s_dat), .gnt(a_gnt)
  );

  m_wbioarb #(.TIMEOUT(15), .FIXEDPRIO(1)) u_b (
    .CLK_I(clk), .RST_NI(rst_n),
    .M0_STB_I(m0_stb), .M0_WE_I(m0_we),
    .M0_ADR_I(m0_adr), .M0_DAT_I(m0_dat),
    .M0_SEL_I(m0_sel), .M0_ACK_O(b_m0_ack),
    .M0_ERR_O(b_m0_err), .M0_DAT_O(b_m0_dat),
    .M1_STB_I(m1_stb), .M1_WE_I(m1_we),
    .M1_ADR_I(m1_adr), .M1_DAT_I(m1_dat),
    .M1_SEL_I(m1_sel), .M1_ACK_O(b_m1_ack),
    .M1_ERR_O(b_m1_err), .M1_DAT_O(b_m1_dat),
    .S_STB_O(b_s_stb), .S_WE_O(b_s_we),
    .S_ADR_O(b_s_adr), .S_DAT_O(b_s_dat),
    .S_SEL_O(b_s_sel), .S_ACK_I(s_ack),
    .S_DAT_I(s_dat), .gnt(b_gnt)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    m0_stb = 1'b0; m0_we = 1'b0;
    m1_stb = 1'b0; m1_we = 1'b0;
    s_ack = 1'b0; s_dat = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_in();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // in = {m0_stb,m0_we,m1_stb,m1_we,s_ack}
  // xf = {s_stb,s_we,gnt_chk,m0_ack,m1_ack}
  typedef struct {
    logic [4:0]  in;
    logic [31:0] sd;
    logic [1:0]  xg;
    logic [4:0]  xf;
    logic [31:0] x0d;
    logic [31:0] x1d;
  } vec_t;

  vec_t v[18];

  logic [1:0] rr_exp[3];
  int stb_hi, acks, errs, ack_at, datbad;

  initial begin
    m0_adr = M0A; m0_dat = M0D; m0_sel = M0S;
    m1_adr = M1A; m1_dat = M1D; m1_sel = M1S;
    idle_in();

    // M0 write, ack on 2nd strobe cycle, ack ignored in RECOVER/IDLE
    v[0]  = '{5'b11000, 32'h0,   2'b00, 5'b00100, 32'h0,    32'h0};
    v[1]  = '{5'b11000, 32'h0,   2'b01, 5'b11100, 32'h0,    32'h0};
    v[2]  = '{5'b11001, 32'hCAFE,2'b01, 5'b11110, 32'hCAFE, 32'h0};
    v[3]  = '{5'b00001, 32'h123, 2'b00, 5'b00000, 32'h0,    32'h0};
    v[4]  = '{5'b00001, 32'h99,  2'b00, 5'b00100, 32'h0,    32'h0};
    // M1 read, data passes same cycle
    v[5]  = '{5'b00100, 32'h0,   2'b00, 5'b00100, 32'h0,    32'h0};
    v[6]  = '{5'b00101, 32'h100, 2'b10, 5'b10101, 32'h0,    32'h100};
    v[7]  = '{5'b00000, 32'h0,   2'b00, 5'b00000, 32'h0,    32'h0};
    v[8]  = '{5'b00000, 32'h0,   2'b00, 5'b00100, 32'h0,    32'h0};
    // M0 aborts on 3rd busy cycle, pending M1 served later
    v[9]  = '{5'b10000, 32'h0,   2'b00, 5'b00100, 32'h0,    32'h0};
    v[10] = '{5'b10100, 32'h0,   2'b01, 5'b10100, 32'h0,    32'h0};
    v[11] = '{5'b10100, 32'h0,   2'b01, 5'b10100, 32'h0,    32'h0};
    v[12] = '{5'b00100, 32'h0,   2'b01, 5'b10100, 32'h0,    32'h0};
    v[13] = '{5'b00100, 32'h0,   2'b00, 5'b00000, 32'h0,    32'h0};
    v[14] = '{5'b00100, 32'h0,   2'b00, 5'b00100, 32'h0,    32'h0};
    v[15] = '{5'b00101, 32'h2A,  2'b10, 5'b10101, 32'h0,    32'h2A};
    v[16] = '{5'b00000, 32'h0,   2'b00, 5'b00000, 32'h0,    32'h0};
    v[17] = '{5'b00000, 32'h0,   2'b00, 5'b00100, 32'h0,    32'h0};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst s_stb", a_s_stb, 0);
    chk("rst s_we", a_s_we, 0);
    chk("rst gnt", a_gnt, 0);
    chk("rst s_adr", a_s_adr, 0);
    chk("rst s_dat", a_s_dat, 0);
    chk("rst s_sel", a_s_sel, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      {m0_stb, m0_we, m1_stb, m1_we, s_ack} = v[i].in;
      s_dat = v[i].sd;
      @(negedge clk);
      chk($sformatf("v%0d s_stb", i), a_s_stb, v[i].xf[4]);
      if (v[i].xf[2])
        chk($sformatf("v%0d gnt", i), a_gnt, v[i].xg);
      chk($sformatf("v%0d m0_ack", i), a_m0_ack, v[i].xf[1]);
      chk($sformatf("v%0d m1_ack", i), a_m1_ack, v[i].xf[0]);
      chk($sformatf("v%0d m0_dat", i), a_m0_dat, v[i].x0d);
      chk($sformatf("v%0d m1_dat", i), a_m1_dat, v[i].x1d);
      chk($sformatf("v%0d errs", i), {a_m0_err, a_m1_err}, 0);
      if (v[i].xf[4]) begin
        chk($sformatf("v%0d s_we", i), a_s_we, v[i].xf[3]);
        chk($sformatf("v%0d s_adr", i), a_s_adr,
            v[i].xg[1] ? M1A : M0A);
        chk($sformatf("v%0d s_dat", i), a_s_dat,
            v[i].xg[1] ? M1D : M0D);
        chk($sformatf("v%0d s_sel", i), a_s_sel,
            v[i].xg[1] ? M1S : M0S);
      end
    end

    // three ties: round-robin M0,M1,M0; fixed M0,M0,M0
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;
    do_reset();
    @(posedge clk); #1;
    m0_stb = 1'b1; m1_stb = 1'b1;
    s_ack = 1'b1; s_dat = 32'h77;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c % 3 == 1) begin
        chk($sformatf("tie%0d rr gnt", c / 3), a_gnt, rr_exp[c / 3]);
        chk($sformatf("tie%0d rr ack", c / 3),
            {a_m1_ack, a_m0_ack}, rr_exp[c / 3]);
        chk($sformatf("tie%0d rr m1dat", c / 3), a_m1_dat,
            rr_exp[c / 3][1] ? 32'h77 : 32'h0);
        chk($sformatf("tie%0d fp gnt", c / 3), b_gnt, 2'b01);
        chk($sformatf("tie%0d fp ack", c / 3),
            {b_m1_ack, b_m0_ack}, 2'b01);
        chk($sformatf("tie%0d fp dat", c / 3),
            {b_m1_dat, b_m0_dat}, {32'h0, 32'h77});
        chk($sformatf("tie%0d fp err", c / 3),
            {b_m1_err, b_m0_err}, 0);
        chk($sformatf("tie%0d fp slave", c / 3),
            {b_s_stb, b_s_we, b_s_sel}, {1'b1, 1'b0, M0S});
        chk($sformatf("tie%0d fp s_adr", c / 3), b_s_adr, M0A);
        chk($sformatf("tie%0d fp s_dat", c / 3), b_s_dat, M0D);
      end else begin
        chk($sformatf("tie c%0d quiet", c),
            {a_s_stb, a_m1_ack, a_m0_ack}, 0);
      end
    end
    @(posedge clk); #1;
    idle_in();

    // slave never acks
    do_reset();
    @(posedge clk); #1;
    m0_stb = 1'b1; m0_we = 1'b1;
    stb_hi = 0; acks = 0; errs = 0; ack_at = -1; datbad = 0;
`ifdef WBIOARB_TIMEOUT_EN
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      stb_hi += int'(a_s_stb);
      acks += int'(a_m0_ack);
      errs += int'(a_m0_err);
      if (a_m0_ack && ack_at < 0) ack_at = c;
      if (a_m0_ack && a_m0_dat != 0) datbad++;
    end
    chk("tmo stb cycles", stb_hi, 15);
    chk("tmo ack pulses", acks, 1);
    chk("tmo err pulses", errs, 1);
    chk("tmo ack cycle", ack_at, 15);
    chk("tmo dat zero", datbad, 0);
    @(posedge clk); #1;
    m0_stb = 1'b0;
    @(negedge clk);
    chk("tmo after stb", a_s_stb, 0);
`else
    for (int c = 0; c < 101; c++) begin
      @(negedge clk);
      stb_hi += int'(a_s_stb);
      acks += int'(a_m0_ack);
      errs += int'(a_m0_err);
    end
    chk("hang stb cycles", stb_hi, 100);
    chk("hang acks", acks, 0);
    chk("hang errs", errs, 0);
    @(posedge clk); #1;
    m0_stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("hang abort stb", a_s_stb, 0);
    chk("hang abort ack", a_m0_ack, 0);
`endif
    @(posedge clk); #1;
    idle_in();
    @(negedge clk);

    // reset mid-BUSY after M0 took the pointer
    do_reset();
    @(posedge clk); #1;
    m0_stb = 1'b1; m0_we = 1'b1; m1_stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid gnt", a_gnt, 2'b01);
    chk("mid stb", a_s_stb, 1);
    m0_adr = 32'hFFFF_0000;
    #1;
    chk("mid adr hold", a_s_adr, M0A);
    m0_adr = M0A;
    @(negedge clk);
    rst_n = 1'b0;
    s_ack = 1'b1;
    #1;
    chk("arst stb", a_s_stb, 0);
    chk("arst gnt", a_gnt, 0);
    chk("arst ack", {a_m0_ack, a_m1_ack, b_m0_ack, b_m1_ack}, 0);
    chk("arst err", {a_m0_err, a_m1_err, b_m0_err, b_m1_err}, 0);
    @(posedge clk); #1;
    chk("arst hold", {a_s_stb, a_gnt, a_m0_ack}, 0);
    @(negedge clk);
    s_ack = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel no early gnt", a_gnt, 0);
    @(negedge clk);
    chk("rel first tie", a_gnt, 2'b01);
    chk("rel stb", a_s_stb, 1);
    @(posedge clk); #1;
    idle_in();
    repeat (3) @(negedge clk);
    chk("end idle", {a_s_stb, a_gnt}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
